// File: rtl/JZJCoreFTypes.sv
// Shared JZJCoreF type/constant package.
// Holds the default debounce depth used by the port input conditioner.
package JZJCoreFTypes;

    // Default number of consecutive differing samples needed to accept a new pin level.
    localparam int PORT_INPUT_DEFAULT_DEBOUNCE = 16;

endpackage : JZJCoreFTypes

// File: rtl/port_input_conditioner_if.sv
// Signal bundle between external pins / port registers and the input conditioner.
// master: the side that drives the pins and the edge-clear port register.
// slave:  the conditioner itself.
interface port_input_conditioner_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] rawInput;
    logic [WIDTH-1:0] edgeClear;
    logic [WIDTH-1:0] levelOut;
    logic [WIDTH-1:0] risingOut;
    logic [WIDTH-1:0] fallingOut;
    logic             anyChange;

    modport master (
        output rawInput,
        output edgeClear,
        input  levelOut,
        input  risingOut,
        input  fallingOut,
        input  anyChange
    );

    modport slave (
        input  rawInput,
        input  edgeClear,
        output levelOut,
        output risingOut,
        output fallingOut,
        output anyChange
    );

endinterface : port_input_conditioner_if

// File: rtl/port_input_bit.sv
// Single-bit input conditioner: synchroniser chain, optional debounce counter,
// sticky rising/falling flags with a level-sensitive clear, and a change strobe.
// Build option: PORT_INPUT_DEBOUNCE_EN enables the debounce counter; without it the
// synchronised level is accepted every cycle.
module port_input_bit
    import JZJCoreFTypes::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = PORT_INPUT_DEFAULT_DEBOUNCE
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    input  logic edge_clear_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic change_o
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("port_input_bit: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous pin through the synchroniser chain.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would collapse the chain.
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    // Sticky edge flags: clear wins over a simultaneous set.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no inferred latch).
        rise_d = rise_q;
        fall_d = fall_q;
        if (edge_clear_i) begin
            rise_d = 1'b0;
            fall_d = 1'b0;
        end else begin
            if (stable_d && !stable_q) rise_d = 1'b1;
            if (!stable_d && stable_q) fall_d = 1'b1;
        end
    end

`ifdef PORT_INPUT_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync != stable_q) begin
            if (cnt_q == CNT_LAST) stable_d = sync;
            else                   cnt_d    = cnt_q + 1'b1;
        end
    end

    // Debounce counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    // Without debounce the synchronised level is taken directly every cycle.
    assign stable_d = sync;
`endif

    // Debounced level and sticky flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level_o  = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign change_o = stable_d ^ stable_q;

endmodule : port_input_bit

// File: rtl/port_input_conditioner.sv
// Conditions WIDTH asynchronous pins for the memory-mapped input ports:
// per-bit synchronise + debounce, sticky edge capture, and a one-cycle anyChange pulse.
// Build option: PORT_INPUT_DEBOUNCE_EN (see port_input_bit) enables debouncing.
module port_input_conditioner
    import JZJCoreFTypes::*;
#(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = PORT_INPUT_DEFAULT_DEBOUNCE
) (
    input  logic                    clock,
    input  logic                    reset,
    port_input_conditioner_if.slave bus
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] change;
    logic             any_change_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        port_input_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clock        (clock),
            .reset        (reset),
            .raw_i        (bus.rawInput[i]),
            .edge_clear_i (bus.edgeClear[i]),
            .level_o      (level[i]),
            .rise_o       (rise[i]),
            .fall_o       (fall[i]),
            .change_o     (change[i])
        );
    end

    // Register the OR of per-bit updates so the pulse aligns with the new levelOut.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) any_change_q <= 1'b0;
        else       any_change_q <= |change;
    end

    assign bus.levelOut   = level;
    assign bus.risingOut  = rise;
    assign bus.fallingOut = fall;
    assign bus.anyChange  = any_change_q;

endmodule : port_input_conditioner

// File: tb/tb_port_input_conditioner.sv
// Directed bench for port_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expected latencies follow the PORT_INPUT_DEBOUNCE_EN build option.
module tb_port_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
`ifdef PORT_INPUT_DEBOUNCE_EN
    localparam int LAT  = SYNC + DEB;
`else
    localparam int LAT  = SYNC + 1;
`endif

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    port_input_conditioner_if #(.WIDTH(32)) bus ();

    port_input_conditioner #(
        .WIDTH           (32),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] raw;
        logic [31:0] clr;
        bit          settle;   // 1: wait LAT+2 edges, 0: wait 2 edges
        logic [31:0] level;
        logic [31:0] rise;
        logic [31:0] fall;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance n active edges, then sample/drive 1 time unit later.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_all();
        bus.edgeClear = '1;
        step(2);
        bus.edgeClear = '0;
        step(1);
    endtask

    function automatic logic [31:0] any32();
        return {31'b0, bus.anyChange};
    endfunction

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'hA5A5_0F0F, 32'h0000_0000, 1'b1, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'h0000_0000};
        vecs[4] = '{32'h5A5A_F0F0, 32'h0000_0000, 1'b1, 32'h5A5A_F0F0, 32'hFFFF_FFFF, 32'hA5A5_0F0F};
        vecs[5] = '{32'h5A5A_F0F0, 32'h0000_FFFF, 1'b0, 32'h5A5A_F0F0, 32'hFFFF_0000, 32'hA5A5_0000};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_F0F0};
        vecs[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        // Reset with all pins high: outputs 0, then a normal debounced rise.
        reset         = 1'b1;
        bus.rawInput  = 32'hFFFF_FFFF;
        bus.edgeClear = '0;
        step(3);
        check("reset_level", bus.levelOut, 32'h0);
        check("reset_rise",  bus.risingOut, 32'h0);
        check("reset_fall",  bus.fallingOut, 32'h0);
        check("reset_any",   any32(), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            check($sformatf("rel_level_e%0d", k), bus.levelOut, (k >= LAT) ? 32'hFFFF_FFFF : 32'h0);
            check($sformatf("rel_any_e%0d", k), any32(), (k == LAT) ? 32'h1 : 32'h0);
        end
        check("rel_rise", bus.risingOut, 32'hFFFF_FFFF);
        check("rel_fall", bus.fallingOut, 32'h0);

        // Table of steady-state patterns; flags accumulate from one row to the next.
        for (int v = 0; v < 8; v++) begin
            bus.rawInput  = vecs[v].raw;
            bus.edgeClear = vecs[v].clr;
            step(vecs[v].settle ? LAT + 2 : 2);
            check($sformatf("vec%0d_level", v), bus.levelOut, vecs[v].level);
            check($sformatf("vec%0d_rise", v),  bus.risingOut, vecs[v].rise);
            check($sformatf("vec%0d_fall", v),  bus.fallingOut, vecs[v].fall);
            check($sformatf("vec%0d_any", v),   any32(), 32'h0);
        end
        bus.edgeClear = '0;
        step(1);

        // Clean rise on bit 0, edge by edge.
        bus.rawInput = 32'h1;
        for (int k = 1; k <= LAT + 2; k++) begin
            step(1);
            check($sformatf("rise0_level_e%0d", k), bus.levelOut, (k >= LAT) ? 32'h1 : 32'h0);
            check($sformatf("rise0_flag_e%0d", k), bus.risingOut, (k >= LAT) ? 32'h1 : 32'h0);
            check($sformatf("rise0_any_e%0d", k), any32(), (k == LAT) ? 32'h1 : 32'h0);
        end
        check("rise0_fall", bus.fallingOut, 32'h0);
        bus.rawInput = '0;
        step(LAT + 2);
        clear_all();

        // Bit 5 high for DEB-1 cycles.
        bus.rawInput = 32'h20;
        step(DEB - 1);
        bus.rawInput = '0;
`ifdef PORT_INPUT_DEBOUNCE_EN
        for (int k = 1; k <= LAT + 3; k++) begin
            step(1);
            check($sformatf("glitch_level_%0d", k), bus.levelOut, 32'h0);
            check($sformatf("glitch_any_%0d", k), any32(), 32'h0);
        end
        check("glitch_rise", bus.risingOut, 32'h0);
        check("glitch_fall", bus.fallingOut, 32'h0);

        // Bit 7 high for exactly DEB cycles is accepted.
        bus.rawInput = 32'h80;
        step(DEB);
        bus.rawInput = '0;
        step(LAT + 2);
        check("boundary_rise",  bus.risingOut, 32'h80);
        check("boundary_fall",  bus.fallingOut, 32'h80);
        check("boundary_level", bus.levelOut, 32'h0);
`else
        step(LAT + 2);
        check("glitch_rise", bus.risingOut, 32'h20);
        check("glitch_fall", bus.fallingOut, 32'h20);
`endif
        clear_all();

        // Clear held across a debounced rise on bit 0.
        bus.edgeClear = 32'h1;
        bus.rawInput  = 32'h1;
        for (int k = 1; k <= LAT + 2; k++) begin
            step(1);
            check($sformatf("clr_rise_e%0d", k), bus.risingOut, 32'h0);
        end
        check("clr_level", bus.levelOut, 32'h1);
        bus.edgeClear = '0;
        step(3);
        check("clr_rel_rise", bus.risingOut, 32'h0);
        check("clr_rel_fall", bus.fallingOut, 32'h0);
        bus.rawInput = '0;
        step(LAT + 2);
        check("clr_fall_set", bus.fallingOut, 32'h1);
        check("clr_fall_rise", bus.risingOut, 32'h0);

        // Reset part-way through a bit-3 debounce (fallingOut[0] is still set).
        bus.rawInput = 32'h8;
        step(LAT - 2);
        reset = 1'b1;
        #1;
        check("midrst_level", bus.levelOut, 32'h0);
        check("midrst_rise",  bus.risingOut, 32'h0);
        check("midrst_fall",  bus.fallingOut, 32'h0);
        check("midrst_any",   any32(), 32'h0);
        step(1);
        reset = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            step(1);
            check($sformatf("midrst_lat_e%0d", k), bus.levelOut, (k >= LAT) ? 32'h8 : 32'h0);
        end
        check("midrst_rise_after", bus.risingOut, 32'h8);

`ifndef PORT_INPUT_DEBOUNCE_EN
        // One-cycle pulse on bit 7 passes straight through.
        bus.rawInput = '0;
        step(LAT + 2);
        clear_all();
        bus.rawInput = 32'h80;
        step(1);
        bus.rawInput = '0;
        step(1);
        check("pulse_level_e2", bus.levelOut, 32'h0);
        step(1);
        check("pulse_level_e3", bus.levelOut, 32'h80);
        check("pulse_rise_e3",  bus.risingOut, 32'h80);
        check("pulse_any_e3",   any32(), 32'h1);
        step(1);
        check("pulse_level_e4", bus.levelOut, 32'h0);
        check("pulse_fall_e4",  bus.fallingOut, 32'h80);
        check("pulse_any_e4",   any32(), 32'h1);
        step(1);
        check("pulse_any_e5",   any32(), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_port_input_conditioner

// File: doc/port_input_conditioner.md
# port_input_conditioner

Conditions asynchronous external signals before they reach the core's memory-mapped input ports at FFFFFFE0–FFFFFFFC. Each bit is synchronised into the core clock domain, then debounced. Rising and falling edges are captured into sticky registers. Software reads the debounced level and sticky edges by wiring `levelOut`, `risingOut` and `fallingOut` to port inputs, and clears edges through a port output wired to `edgeClear`.

## Interface
- `WIDTH`, 32, number of conditioned bits
- `SYNC_STAGES`, 2, synchroniser flip-flops per bit (≥2)
- `DEBOUNCE_CYCLES`, 16, consecutive differing cycles required to accept a new level (≥1)
- `clock` in 1: core clock
- `reset` in 1: asynchronous, active-high reset
- `rawInput` in WIDTH: external pins, asynchronous to `clock`
- `edgeClear` in WIDTH: level-sensitive per-bit clear of sticky edge bits, driven from a port output register
- `levelOut` out WIDTH: debounced level, intended for a port input
- `risingOut` out WIDTH: sticky 0→1 flags on `levelOut`
- `fallingOut` out WIDTH: sticky 1→0 flags on `levelOut`
- `anyChange` out 1: high for exactly one cycle after any `levelOut` bit changes

## Operation
- **Synchroniser:** each `rawInput` bit shifts through `SYNC_STAGES` flops. `sync[i]` is the last stage.
- **Debounce:** each bit has a `stable` register (drives `levelOut[i]`) and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sync[i] == stable[i]`, the counter is set to 0.
  - Else, if counter == `DEBOUNCE_CYCLES-1`, then `stable[i] <= sync[i]` and the counter is set to 0.
  - Else the counter increments.
  - Net effect: a glitch shorter than `DEBOUNCE_CYCLES` sampled cycles is discarded, and the counter never wraps.
- **Edge capture:** on the clock edge where `stable[i]` changes:
  - for 0→1, set `risingOut[i]`;
  - for 1→0, set `fallingOut[i]`.
- **Clear priority:** while `edgeClear[i]`=1, `risingOut[i]` and `fallingOut[i]` are forced to 0. Clear beats a simultaneous set. Sticky bits set again only on a new edge after the clear is released.
- **anyChange:** registered OR of all per-bit update events. It is high in the cycle following the edge on which `levelOut` changed.
- **Independence:** bits are fully independent; simultaneous changes on any subset are all captured.
- **Reset:** asynchronously clears synchroniser flops, `stable`, counters, sticky flags and `anyChange`. All outputs read 0 during reset.
  - Pins already high at reset release produce a normal debounced rise and set `risingOut`.

## Timing
- A pin level present before clock edge 1 appears on `sync` after edge `SYNC_STAGES`.
- `levelOut` and the sticky flag update at edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- `anyChange` is high for the following cycle only.
- `edgeClear` takes effect at the next clock edge (one-cycle latency).
- No handshake. Outputs are registered and stable between edges, so they are safe for direct combinational reads by the memory controller.

## Configuration
- **`PORT_INPUT_DEBOUNCE_EN` defined:** debounce counters are built as described above.
- **Not defined:**
  - no counters; `DEBOUNCE_CYCLES` is ignored;
  - `stable[i] <= sync[i]` every cycle, so latency is `SYNC_STAGES + 1` edges;
  - edge capture, clear and `anyChange` behave identically.

## Structure
- Add a constant `PORT_INPUT_DEFAULT_DEBOUNCE = 16` to the shared package `JZJCoreFTypes`. No new typedefs are needed.
- One sub-module, `port_input_bit`, contains the synchroniser, debounce, edge flags and clear logic for a single bit. The top level instantiates it `WIDTH` times with a generate loop and ORs the per-bit change strobes into `anyChange`.

## Test plan
Parameters for all scenarios: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4.
- **Reset:** hold `reset`=1 with `rawInput`=32'hFFFF_FFFF → all outputs 0. After release, `levelOut` becomes FFFF_FFFF at edge 6, `risingOut`=FFFF_FFFF, and `anyChange` pulses for 1 cycle.
- **Clean rise:** `rawInput[0]` 0→1 → `levelOut[0]`=1 and `risingOut[0]`=1 at edge 6; `anyChange` is high in cycle 7 only; `fallingOut`=0.
- **Glitch:** `rawInput[5]` high for 3 cycles, then low → `levelOut[5]`, `risingOut[5]` and `anyChange` stay 0 throughout.
- **Clear priority:** hold `edgeClear[0]`=1 across a debounced rise on bit 0 → `risingOut[0]` stays 0 while `levelOut[0]`=1. After release, it stays 0 until the next falling edge sets `fallingOut[0]`.
- **Reset mid-debounce:** assert `reset` 2 cycles into a 4-cycle debounce on bit 3 → outputs clear immediately. After release, a full 6-edge latency is required again.
- **Macro off:** with `PORT_INPUT_DEBOUNCE_EN` undefined, a 1-cycle high on bit 7 → `levelOut[7]` pulses for 1 cycle at edge 3, and `risingOut[7]` and `fallingOut[7]` are both set.
